// File: rtl/pre_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pre_ram_pkg
// Brief    : Shared geometry constants and types for the pre-RAM line buffer.
// Revision : 1.0 - initial release
// ============================================================================
package pre_ram_pkg;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int WIN    = 32;
    localparam int OUT_W  = WIN * DATA_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // The address width matches DEPTH exactly, so plain addition wraps modulo DEPTH.
    function automatic addr_t win_index(input addr_t base, input int offset);
        return base + addr_t'(offset);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pre_ram_window_mux.sv
`default_nettype none
// ============================================================================
// Module   : pre_ram_window_mux
// Brief    : Combinational selector of WIN consecutive words, wrapping at DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module pre_ram_window_mux
    import pre_ram_pkg::*;
(
    input  logic [DEPTH*DATA_W-1:0] mem,
    input  logic [ADDR_W-1:0]       addr,
    output logic [OUT_W-1:0]        window
);

    for (genvar i = 0; i < WIN; i++) begin : g_win
        addr_t w_idx;
        assign w_idx = win_index(addr, i);
        assign window[i*DATA_W +: DATA_W] = mem[int'(w_idx)*DATA_W +: DATA_W];
    end

endmodule
`default_nettype wire

// File: rtl/pre_ram_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : pre_ram_line_buf
// Brief    : Register-based pre-load buffer; single-word host writes, 32-word
//            window reads with 1-cycle latency. Optional macro
//            PRE_RAM_BYPASS_EN forwards data_in into window word 0 on a
//            simultaneous write/read at the same address.
// Revision : 1.0 - initial release
// ============================================================================
module pre_ram_line_buf
    import pre_ram_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic                read_req,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    output logic [OUT_W-1:0]    data_out,
    output logic                rd_valid
);

    logic [DEPTH*DATA_W-1:0] r_mem;
    logic [OUT_W-1:0]        r_data_out;
    logic                    r_rd_valid;
    logic [OUT_W-1:0]        w_window;
    logic [OUT_W-1:0]        w_rd_data;

    pre_ram_window_mux u_window_mux (
        .mem    (r_mem),
        .addr   (addr),
        .window (w_window)
    );

    always_comb begin
        w_rd_data = w_window;
`ifdef PRE_RAM_BYPASS_EN
        if (we) begin
            w_rd_data[DATA_W-1:0] = data_in;
        end
`endif
    end

    // reset_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_mem      <= '0;
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (we) begin
                r_mem[int'(addr)*DATA_W +: DATA_W] <= data_in;
            end
            if (read_req) begin
                r_data_out <= w_rd_data;
            end
            r_rd_valid <= read_req;
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_pre_ram_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pre_ram_line_buf
// Brief    : Self-checking bench for pre_ram_line_buf against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pre_ram_line_buf;

    logic           clk;
    logic           reset_n;
    logic           we;
    logic           read_req;
    logic [7:0]     addr;
    logic [63:0]    data_in;
    logic [2047:0]  data_out;
    logic           rd_valid;

    logic [63:0]    ref_mem [256];
    logic [2047:0]  exp_out;
    logic           exp_valid;
    int             n_cmp;
    int             n_fail;

    pre_ram_line_buf dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (we),
        .read_req (read_req),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2047:0] model_window(input int a);
        logic [2047:0] w;
        for (int i = 0; i < 32; i++) begin
            w[i*64 +: 64] = ref_mem[(a + i) % 256];
        end
        return w;
    endfunction

    function automatic int first_diff(input logic [2047:0] a, input logic [2047:0] b);
        for (int i = 0; i < 32; i++) begin
            if (a[i*64 +: 64] !== b[i*64 +: 64]) return i;
        end
        return 0;
    endfunction

    // Drives one clock of stimulus and advances the model; outputs are
    // sampled 1 time unit after the edge by the calling test.
    task automatic step(input logic rs, input logic w, input logic r,
                        input logic [7:0] a, input logic [63:0] d);
        reset_n  = rs;
        we       = w;
        read_req = r;
        addr     = a;
        data_in  = d;
        if (rs) begin
            for (int k = 0; k < 256; k++) ref_mem[k] = '0;
            exp_out   = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = r;
            if (r) begin
                exp_out = model_window(int'(a));
`ifdef PRE_RAM_BYPASS_EN
                if (w) exp_out[63:0] = d;
`endif
            end
            if (w) ref_mem[a] = d;
        end
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        we       = 1'b0;
        read_req = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 8'd0, 64'd0);
        step(1, 0, 0, 8'd0, 64'd0);
        n_cmp++;
        if (rd_valid !== 1'b0 || data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state rd_valid=%b word0=%h required rd_valid=0 data_out=0",
                     rd_valid, data_out[63:0]);
        end
        step(0, 0, 1, 8'd0, 64'd0);
        n_cmp++;
        if (rd_valid !== 1'b1 || data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_read rd_valid=%b word%0d=%h required rd_valid=1 data_out=0",
                     rd_valid, first_diff(data_out, '0), data_out[first_diff(data_out, '0)*64 +: 64]);
        end
        step(0, 0, 0, 8'd0, 64'd0);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulse rd_valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_write_read();
        int k;
        step(0, 1, 0, 8'd10, 64'hA5A5A5A5A5A5A5A5);
        step(0, 1, 0, 8'd20, 64'h5A5A5A5A5A5A5A5A);
        step(0, 0, 1, 8'd10, 64'd0);
        n_cmp++;
        if (data_out[63:0] !== 64'hA5A5A5A5A5A5A5A5) begin
            n_fail++;
            $display("FAIL wr_word0 got %h required a5a5a5a5a5a5a5a5", data_out[63:0]);
        end
        n_cmp++;
        if (data_out[703:640] !== 64'h5A5A5A5A5A5A5A5A) begin
            n_fail++;
            $display("FAIL wr_word10 got %h required 5a5a5a5a5a5a5a5a", data_out[703:640]);
        end
        n_cmp++;
        if (data_out !== exp_out || rd_valid !== 1'b1) begin
            k = first_diff(data_out, exp_out);
            n_fail++;
            $display("FAIL wr_window word%0d got %h required %h rd_valid=%b",
                     k, data_out[k*64 +: 64], exp_out[k*64 +: 64], rd_valid);
        end
    endtask

    task automatic test_wrap();
        int k;
        step(0, 1, 0, 8'd0,   64'h0000000000000001);
        step(0, 1, 0, 8'd255, 64'hFFFF000000000000);
        step(0, 0, 1, 8'd240, 64'd0);
        n_cmp++;
        if (data_out[15*64 +: 64] !== 64'hFFFF000000000000) begin
            n_fail++;
            $display("FAIL wrap_word15 got %h required ffff000000000000", data_out[15*64 +: 64]);
        end
        n_cmp++;
        if (data_out[16*64 +: 64] !== 64'h0000000000000001) begin
            n_fail++;
            $display("FAIL wrap_word16 got %h required 0000000000000001", data_out[16*64 +: 64]);
        end
        n_cmp++;
        if (data_out !== exp_out) begin
            k = first_diff(data_out, exp_out);
            n_fail++;
            $display("FAIL wrap_window word%0d got %h required %h",
                     k, data_out[k*64 +: 64], exp_out[k*64 +: 64]);
        end
    endtask

    task automatic test_hold();
        logic [2047:0] held;
        int k;
        held = exp_out;
        step(0, 1, 0, 8'd10, 64'h1234);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (data_out !== held || rd_valid !== 1'b0) begin
                k = first_diff(data_out, held);
                n_fail++;
                $display("FAIL hold cycle%0d word%0d got %h required %h rd_valid=%b required 0",
                         c, k, data_out[k*64 +: 64], held[k*64 +: 64], rd_valid);
            end
            if (c < 2) step(0, 0, 0, 8'd0, 64'd0);
        end
        step(0, 0, 1, 8'd10, 64'd0);
        n_cmp++;
        if (data_out[63:0] !== 64'h1234 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_reread got %h rd_valid=%b required 1234 rd_valid=1",
                     data_out[63:0], rd_valid);
        end
    endtask

    task automatic test_collision();
        logic [63:0] want;
`ifdef PRE_RAM_BYPASS_EN
        want = 64'h2222222222222222;
`else
        want = 64'h1111111111111111;
`endif
        step(0, 1, 0, 8'd5, 64'h1111111111111111);
        step(0, 1, 1, 8'd5, 64'h2222222222222222);
        n_cmp++;
        if (data_out[63:0] !== want || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_word0 got %h required %h rd_valid=%b",
                     data_out[63:0], want, rd_valid);
        end
        step(0, 0, 1, 8'd5, 64'd0);
        n_cmp++;
        if (data_out[63:0] !== 64'h2222222222222222) begin
            n_fail++;
            $display("FAIL collision_after got %h required 2222222222222222", data_out[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        step(0, 1, 0, 8'd100, 64'hDEADBEEF00000064);
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 1, 8'(90 + c * 5), 64'd0);
            n_cmp++;
            if (data_out !== exp_out || rd_valid !== 1'b1) begin
                k = first_diff(data_out, exp_out);
                n_fail++;
                $display("FAIL b2b read%0d word%0d got %h required %h rd_valid=%b",
                         c, k, data_out[k*64 +: 64], exp_out[k*64 +: 64], rd_valid);
            end
        end
    endtask

    task automatic test_random();
        int k;
        for (int c = 0; c < 300; c++) begin
            step(($urandom % 60) == 0, 1'($urandom), 1'($urandom), 8'($urandom),
                 {$urandom, $urandom});
            n_cmp++;
            if (data_out !== exp_out || rd_valid !== exp_valid) begin
                k = first_diff(data_out, exp_out);
                n_fail++;
                $display("FAIL random cyc%0d word%0d got %h required %h rd_valid=%b required %b",
                         c, k, data_out[k*64 +: 64], exp_out[k*64 +: 64], rd_valid, exp_valid);
            end
        end
    endtask

    task automatic test_midop_reset();
        int k;
        for (int j = 0; j < 16; j++) step(0, 1, 0, 8'(j * 16 + 3), {$urandom, $urandom} | 64'd1);
        step(0, 0, 1, 8'd0, 64'd0);
        step(1, 0, 1, 8'd3, 64'd0);
        n_cmp++;
        if (data_out !== '0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset word0=%h rd_valid=%b required 0 and 0", data_out[63:0], rd_valid);
        end
        for (int j = 0; j < 8; j++) begin
            step(0, 0, 1, 8'(j * 32), 64'd0);
            n_cmp++;
            if (data_out !== '0 || rd_valid !== 1'b1) begin
                k = first_diff(data_out, '0);
                n_fail++;
                $display("FAIL midop_mem base%0d word%0d got %h required 0 rd_valid=%b",
                         j * 32, k, data_out[k*64 +: 64], rd_valid);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset_n   = 1'b1;
        we        = 1'b0;
        read_req  = 1'b0;
        addr      = '0;
        data_in   = '0;
        exp_out   = '0;
        exp_valid = 1'b0;
        for (int k = 0; k < 256; k++) ref_mem[k] = '0;
        test_reset();
        test_write_read();
        test_wrap();
        test_hold();
        test_collision();
        test_back_to_back();
        test_random();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
